noc_in_buf: RTL
===============

# noc_in_buf

Per-port input flit buffer for the 2D-mesh router, sitting directly upstream of route computation. Accepts 40-bit flits from the inbound link with a valid/ready handshake and stores them in a small circular FIFO. Presents the head flit show-ahead to the route-computation stage, which pops it through its `fifo_ready` output. Also exports occupancy and almost-full status for link-level flow control.

## Interface
- `DATASIZE`, 40: flit width; layout {src[3:0], dst[3:0], timestamp[7:0], data[21:0], type[1:0]}, bit 0 = request flag.
- `DEPTH`, 4: entries; power of two, ≥2.
- `AFULL_TH`, 3: `almost_full` asserts when `count` ≥ `AFULL_TH`; 1 ≤ `AFULL_TH` ≤ `DEPTH`.
- `rc_clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATASIZE  flit from link.
- `in_valid`  in  1  `in_data` valid this cycle.
- `in_ready`  out  1  buffer can accept; equals `!full`.
- `out_data`  out  DATASIZE  head flit; drives route computation `data_in`.
- `out_valid`  out  1  head flit present; drives route computation `valid_in`.
- `out_ready`  in  1  downstream takes head this cycle; from route computation `fifo_ready`.
- `count`  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `almost_full`  out  1  `count` ≥ `AFULL_TH`.

## Operation
- push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- Storage: DEPTH×DATASIZE register array.
- `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit.
  - full ⇔ index bits equal and wrap bits differ.
  - empty ⇔ pointers equal.
  - Pointers wrap modulo 2·DEPTH.
- On push, write the array at `wr_ptr` and increment it. On pop, increment `rd_ptr`.
- `count` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, or on neither.
- Simultaneous push and pop:
  - When empty: push only, since `out_valid` = 0. No bypass.
  - When full: pop only, since `in_ready` = 0. There is no combinational path from `out_ready` to `in_ready`.
  - Otherwise: both happen, and `count` is held.
- `out_data` = array[`rd_ptr`] read combinationally. `out_valid` = `!empty`.
  - When empty, `out_data` holds the last-written contents of that slot and must not be interpreted.
- `out_data` is stable while `out_valid && !out_ready`. Head-of-line order is strictly FIFO.
- `in_data` is ignored when no push occurs. `out_ready` is ignored when empty.
- Contents are never inspected; the buffer forwards request and response flits identically.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers and `count` go to 0. `empty`=1, `full`=0, `almost_full`=0, `in_ready`=1, `out_valid`=0.
  - Array contents are cleared to 0, so `out_data`=0.
  - In-flight flits are discarded.

## Timing
- Push → `out_valid`: 1 cycle. A flit pushed at edge N is visible at `out_data` after edge N.
- Pop takes effect at the edge where `out_valid && out_ready`. The next flit, if any, is visible after that edge.
- Sustained throughput: 1 flit per cycle when neither full nor empty.
- `in_ready`, `full`, `empty`, `almost_full`, `count` and `out_valid` are all derived from registered state only.
- Back-to-back full→pop→push: `in_ready` rises the cycle after the pop edge.

## Structure
- Flit field widths (`ADDR_WIDTH`, `TIME_WIDTH`, `PDATA_WIDTH`) come from the shared `noc_define.v`.
- No new shared constants are needed beyond a `FLIT_REQ_BIT` index (0), added to `noc_define.v`.
- One flat module; no sub-module. Pointer compare and count logic are small enough to live inline.

## Test plan
- Reset with `in_valid`=1 → `in_ready`=1, `out_valid`=0, `count`=0, `empty`=1, `out_data`=0 throughout reset.
- Push 0xAA_0000_0001 at edge 1 with `out_ready`=0 → after edge 1: `out_valid`=1, `out_data`=0xAA_0000_0001, `count`=1.
- Push 4 flits A,B,C,D with `out_ready`=0 (DEPTH=4):
  - After the 3rd push, `almost_full`=1.
  - After the 4th push, `full`=1 and `in_ready`=0.
  - A 5th flit E held on `in_valid` is not accepted; `count` stays 4.
- Full state with `out_ready`=1 and `in_valid`=1 (E):
  - Edge 1: pop of A only; `count`=3, `out_data`=B.
  - Edge 2: push of E and pop of B; `count`=3, `out_data`=C.
  - Drain continues as C, D, E in order.
- Continuous streaming of 20 flits with `in_valid`=`out_ready`=1 → 1-cycle fill, then one flit per cycle out in order. Pointers wrap at least twice; `count` stays 1.
- Assert `rst_n`=0 mid-stream with `count`=2 → asynchronously `count`=0, `out_valid`=0, `in_ready`=1. After release, the first new push appears intact at the head.

Source files
------------

// File: rtl/noc_in_buf_pkg.sv
// noc_in_buf_pkg
//   Flit layout constants shared by the mesh router input stage.
//   A flit is {src, dst, timestamp, data, type}. Bit 0 (the low bit of
//   the type field) marks a request flit.
//   Contents: field widths, total flit width, request-flag index, a
//   packed flit struct and a small decode helper.
package noc_in_buf_pkg;

  localparam int ADDR_WIDTH   = 4;
  localparam int TIME_WIDTH   = 8;
  localparam int PDATA_WIDTH  = 22;
  localparam int TYPE_WIDTH   = 2;
  localparam int FLIT_WIDTH   = 2*ADDR_WIDTH + TIME_WIDTH + PDATA_WIDTH + TYPE_WIDTH;
  localparam int FLIT_REQ_BIT = 0;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  src;
    logic [ADDR_WIDTH-1:0]  dst;
    logic [TIME_WIDTH-1:0]  timestamp;
    logic [PDATA_WIDTH-1:0] data;
    logic [TYPE_WIDTH-1:0]  ftype;
  } flit_t;

  function automatic logic is_request(input logic [FLIT_WIDTH-1:0] flit);
    return flit[FLIT_REQ_BIT];
  endfunction

endpackage

// File: rtl/noc_in_buf.sv
// noc_in_buf
//   Per-port input flit buffer ahead of route computation. A small
//   circular FIFO with show-ahead head output. Flit contents are never
//   inspected; requests and responses are forwarded identically.
// Ports
//   rc_clk       in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   in_data      in   flit from link
//   in_valid     in   in_data valid
//   in_ready     out  buffer can accept (== !full)
//   out_data     out  head flit (route computation data_in)
//   out_valid    out  head flit present
//   out_ready    in   route computation takes head this cycle
//   count        out  occupancy 0..DEPTH
//   full         out  count == DEPTH
//   empty        out  count == 0
//   almost_full  out  count >= AFULL_TH
module noc_in_buf
  import noc_in_buf_pkg::*;
#(
  parameter int DATASIZE = FLIT_WIDTH,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                     rc_clk,
  input  logic                     rst_n,
  input  logic [DATASIZE-1:0]      in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATASIZE-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATASIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    count_q;
  logic                push;
  logic                pop;

  // Pointers carry one extra wrap bit: same index with differing wrap
  // bits means the writer is a full lap ahead of the reader.
  assign full        = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                       (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign empty       = (wr_ptr == rd_ptr);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign count       = count_q;
  assign almost_full = (count_q >= PTR_W'(AFULL_TH));

  // Gating by in_ready/out_valid rules out bypass when empty and keeps
  // in_ready independent of out_ready when full.
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Show-ahead head read; when empty this is stale and ignored downstream.
  assign out_data = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge rc_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[IDX_W-1:0]] <= in_data;
        wr_ptr                 <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + PTR_W'(1);
        2'b01:   count_q <= count_q - PTR_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
